srec_write_packer: RTL and testbench



---
 rtl/mem_pkg.sv | 28 ++
 rtl/srec_write_packer_lane_select.sv | 20 ++
 rtl/srec_write_packer.sv | 179 +++++++++++++++++
 tb/tb_srec_write_packer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions for the SREC load path.
//   ACCESS_BYTE / ACCESS_WORD : mem_access_size encodings
//   packer_state_t            : srec_write_packer control states
//   INSTRUCTION_OFFSET        : base of the loaded program image
//   lane_byte()               : extract a big-endian byte lane from a word
package mem_pkg;

  localparam logic [1:0]  ACCESS_BYTE        = 2'b00;
  localparam logic [1:0]  ACCESS_WORD        = 2'b10;
  localparam logic [31:0] INSTRUCTION_OFFSET = 32'h8002_0000;

  typedef enum logic [1:0] {
    COLLECT,
    WORD_OUT,
    DRAIN
  } packer_state_t;

  // Lane 0 is the most significant byte (big-endian memory).
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/srec_write_packer_lane_select.sv
// Priority encoder for the packer's byte-lane mask.
//   mask : valid byte lanes
//   lane : index of the lowest set lane (0 when mask is empty)
//   any  : at least one lane is set
module lane_select (
  input  logic [3:0] mask,
  output logic [1:0] lane,
  output logic       any
);

  always_comb begin
    any  = |mask;
    lane = '0;
    if      (mask[0]) lane = 2'd0;
    else if (mask[1]) lane = 2'd1;
    else if (mask[2]) lane = 2'd2;
    else if (mask[3]) lane = 2'd3;
  end

endmodule

// File: rtl/srec_write_packer.sv
// Coalesces the SREC parser's single-byte writes into aligned 32-bit word
// writes; bytes that cannot complete a word are drained as byte writes.
//   clk, reset                 : clock, async active-high reset
//   in_valid/in_ready          : byte handshake from the parser
//   in_address, in_data        : byte address and value
//   flush                      : drain any partial word (level)
//   mem_write/mem_ready        : registered write request / accept
//   mem_address, mem_data_in   : write address and data (bytes in [7:0])
//   mem_access_size            : ACCESS_BYTE or ACCESS_WORD
//   idle                       : nothing buffered, no pending write
//   write_count                : completed write transactions (wraps)
module srec_write_packer
  import mem_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_address,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             mem_write,
  input  logic             mem_ready,
  output logic [31:0]      mem_address,
  output logic [31:0]      mem_data_in,
  output logic [1:0]       mem_access_size,
  output logic             idle,
  output logic [CNT_W-1:0] write_count
);

  packer_state_t    state_q, state_d;
  logic [29:0]      base_q, base_d;
  logic [31:0]      buf_q, buf_d;
  logic [3:0]       mask_q, mask_d;
  logic             mem_write_q, mem_write_d;
  logic [31:0]      mem_address_q, mem_address_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]  in_lane;
  logic [3:0]  in_lane_bit;
  logic        accept;
  logic [3:0]  m_mask;
  logic [29:0] m_base;
  logic [31:0] m_buf;
  logic [3:0]  drain_mask;
  logic [3:0]  sel_mask;
  logic [1:0]  sel_lane;
  logic        sel_any;

  // In DRAIN the lane being emitted is held in mem_address_q[1:0], so the
  // encoder looks ahead at the mask with that lane removed; in COLLECT it
  // looks at the merged mask to pick the first drain lane.
  assign drain_mask = mask_q & ~(4'b0001 << mem_address_q[1:0]);
  assign sel_mask   = (state_q == DRAIN) ? drain_mask : m_mask;

  lane_select u_lane_select (
    .mask (sel_mask),
    .lane (sel_lane),
    .any  (sel_any)
  );

  always_comb begin
    in_lane     = in_address[1:0];
    in_lane_bit = 4'b0001 << in_lane;
    in_ready    = (state_q == COLLECT) &&
                  ((mask_q == '0) ||
                   ((in_address[31:2] == base_q) && ((mask_q & in_lane_bit) == '0)));
    accept      = in_valid && in_ready;

    m_mask = mask_q;
    m_base = base_q;
    m_buf  = buf_q;
    if (accept) begin
      m_mask = mask_q | in_lane_bit;
      if (mask_q == '0) m_base = in_address[31:2];
      case (in_lane)
        2'd0:    m_buf[31:24] = in_data;
        2'd1:    m_buf[23:16] = in_data;
        2'd2:    m_buf[15:8]  = in_data;
        default: m_buf[7:0]   = in_data;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    buf_d         = buf_q;
    mask_d        = mask_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_size_d    = mem_size_q;
    count_d       = count_q;

    case (state_q)
      COLLECT: begin
        base_d = m_base;
        buf_d  = m_buf;
        mask_d = m_mask;
        if (m_mask == 4'hF) begin
          state_d       = WORD_OUT;
          mem_write_d   = 1'b1;
          mem_address_d = {m_base, 2'b00};
          mem_data_d    = m_buf;
          mem_size_d    = ACCESS_WORD;
        end else if ((m_mask != '0) && ((in_valid && !in_ready) || flush)) begin
          state_d       = DRAIN;
          mem_write_d   = 1'b1;
          mem_address_d = {m_base, sel_lane};
          mem_data_d    = {24'h0, lane_byte(m_buf, sel_lane)};
          mem_size_d    = ACCESS_BYTE;
        end
      end
      WORD_OUT: begin
        if (mem_ready) begin
          state_d     = COLLECT;
          mask_d      = '0;
          mem_write_d = 1'b0;
          count_d     = count_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          mask_d  = drain_mask;
          count_d = count_q + CNT_W'(1);
          if (!sel_any) begin
            state_d     = COLLECT;
            mem_write_d = 1'b0;
          end else begin
            mem_address_d = {base_q, sel_lane};
            mem_data_d    = {24'h0, lane_byte(buf_q, sel_lane)};
          end
        end
      end
      default: begin
        state_d     = COLLECT;
        mask_d      = '0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      base_q        <= '0;
      buf_q         <= '0;
      mask_q        <= '0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_size_q    <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      buf_q         <= buf_d;
      mask_q        <= mask_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_size_q    <= mem_size_d;
      count_q       <= count_d;
    end
  end

  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_data_in     = mem_data_q;
  assign mem_access_size = mem_size_q;
  assign write_count     = count_q;
  assign idle            = (state_q == COLLECT) && (mask_q == '0);

endmodule

// File: tb/tb_srec_write_packer.sv
// Self-checking bench for srec_write_packer: directed scenarios plus
// randomized byte streams against a transaction-level packing model.
module tb_srec_write_packer;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_address;
  logic [7:0]  in_data;
  logic        flush;
  logic        mem_write;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_access_size;
  logic        idle;
  logic [15:0] write_count;

  always #5 clk = ~clk;

  srec_write_packer #(.CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_address      (in_address),
    .in_data         (in_data),
    .flush           (flush),
    .mem_write       (mem_write),
    .mem_ready       (mem_ready),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_access_size (mem_access_size),
    .idle            (idle),
    .write_count     (write_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: one buffered word of byte lanes.
  logic [29:0] m_base;
  logic [7:0]  m_buf[4];
  logic [3:0]  m_mask = '0;
  int unsigned m_cnt  = 0;

  bit          mon_en     = 0;
  bit          prev_stall = 0;
  bit          hs_seen    = 0;
  bit          last_rdy   = 0;
  int          ready_mode = 1;  // 0: low, 1: high, 2: random
  logic [31:0] pa, pd;
  logic [1:0]  ps;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_drain();
    for (int l = 0; l < 4; l++)
      if (m_mask[l]) exp_q.push_back('{{m_base, 2'(l)}, {24'h0, m_buf[l]}, ACCESS_BYTE});
    m_mask = '0;
  endtask

  task automatic model_byte(input logic [31:0] addr, input logic [7:0] data, input bit fl);
    logic [1:0] l;
    l = addr[1:0];
    if (m_mask != '0 && (addr[31:2] != m_base || m_mask[l])) model_drain();
    if (m_mask == '0) m_base = addr[31:2];
    m_buf[l]  = data;
    m_mask[l] = 1'b1;
    if (m_mask == 4'hF) begin
      exp_q.push_back('{{m_base, 2'b00}, {m_buf[0], m_buf[1], m_buf[2], m_buf[3]}, ACCESS_WORD});
      m_mask = '0;
    end else if (fl) begin
      model_drain();
    end
  endtask

  task automatic monitor_step();
    wr_t e;
    check("write_count", 32'(write_count), m_cnt & 32'hFFFF);
    if (prev_stall) begin
      check("hold_write", 32'(mem_write), 1);
      check("hold_addr", mem_address, pa);
      check("hold_data", mem_data_in, pd);
      check("hold_size", 32'(mem_access_size), 32'(ps));
    end
    if (mem_write && mem_ready) begin
      hs_seen = 1;
      if (exp_q.size() == 0) begin
        check("spurious_write", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_address, e.a);
        check("wr_data", mem_data_in, e.d);
        check("wr_size", 32'(mem_access_size), 32'(e.s));
      end
      m_cnt++;
    end
    prev_stall = mem_write && !mem_ready;
    pa = mem_address;
    pd = mem_data_in;
    ps = mem_access_size;
  endtask

  // One clock: observe at the falling edge, update mem_ready after the rise.
  task automatic tick();
    @(negedge clk);
    if (mon_en) monitor_step();
    last_rdy = in_ready;
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       mem_ready = 1'b0;
      1:       mem_ready = 1'b1;
      default: mem_ready = 1'($urandom % 2);
    endcase
  endtask

  task automatic send_byte(input logic [31:0] addr, input logic [7:0] data, input bit fl,
                           output bit first_rdy);
    bit acc;
    acc       = 0;
    first_rdy = 0;
    model_byte(addr, data, fl);
    in_valid   = 1'b1;
    in_address = addr;
    in_data    = data;
    flush      = fl;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 0) first_rdy = last_rdy;
      if (last_rdy) begin
        acc = 1;
        break;
      end
    end
    if (!acc) check("accept_timeout", 32'(acc), 1);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (idle && !mem_write && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'(done), 1);
  endtask

  task automatic do_flush();
    model_drain();
    flush = 1'b1;
    wait_idle();
    flush = 1'b0;
  endtask

  initial begin
    bit          r;
    logic [31:0] a;
    int unsigned cnt_before;

    reset      = 1'b1;
    in_valid   = 1'b0;
    in_address = '0;
    in_data    = '0;
    flush      = 1'b0;
    mem_ready  = 1'b1;
    #1;
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data_in, 0);
    check("rst_size", 32'(mem_access_size), 0);
    check("rst_count", 32'(write_count), 0);
    check("rst_idle", 32'(idle), 1);
    check("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1;

    // Full word, ready high: write appears the cycle after the last byte.
    ready_mode = 1;
    send_byte(INSTRUCTION_OFFSET + 0, 8'h27, 0, r);
    send_byte(INSTRUCTION_OFFSET + 1, 8'hBD, 0, r);
    send_byte(INSTRUCTION_OFFSET + 2, 8'hFF, 0, r);
    send_byte(INSTRUCTION_OFFSET + 3, 8'hE8, 0, r);
    check("word_next_cycle", 32'(mem_write), 1);
    check("word_size", 32'(mem_access_size), 32'(ACCESS_WORD));
    check("word_data", mem_data_in, 32'h27BD_FFE8);
    wait_idle();
    check("word_count", 32'(write_count), 1);

    // Discontinuity: CC stalls, two byte writes, then CC is held.
    send_byte(INSTRUCTION_OFFSET + 4, 8'hAA, 0, r);
    send_byte(INSTRUCTION_OFFSET + 5, 8'hBB, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h10, 8'hCC, 0, r);
    check("discont_in_ready", 32'(r), 0);
    check("discont_held_idle", 32'(idle), 0);
    do_flush();

    // Backpressure: request held steady for four cycles, counted once.
    cnt_before = m_cnt;
    ready_mode = 0;
    send_byte(INSTRUCTION_OFFSET + 32'h40, 8'h01, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h41, 8'h02, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h42, 8'h03, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h43, 8'h04, 0, r);
    for (int k = 0; k < 4; k++) begin
      check("bp_write", 32'(mem_write), 1);
      check("bp_addr", mem_address, INSTRUCTION_OFFSET + 32'h40);
      check("bp_data", mem_data_in, 32'h0102_0304);
      if (k < 3) tick();
    end
    ready_mode = 1;
    wait_idle();
    check("bp_count", 32'(write_count), (cnt_before + 1) & 32'hFFFF);

    // Flush colliding with the completing byte, then a single-lane flush.
    send_byte(INSTRUCTION_OFFSET + 32'h30, 8'h10, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h31, 8'h20, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h32, 8'h30, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h33, 8'h40, 1, r);
    check("flush_word_size", 32'(mem_access_size), 32'(ACCESS_WORD));
    wait_idle();
    send_byte(INSTRUCTION_OFFSET + 32'h51, 8'h5A, 1, r);
    wait_idle();

    // Duplicate lane.
    send_byte(INSTRUCTION_OFFSET + 8, 8'h11, 0, r);
    send_byte(INSTRUCTION_OFFSET + 8, 8'h22, 0, r);
    check("dup_in_ready", 32'(r), 0);
    do_flush();

    // Flush with nothing buffered must not produce a write.
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    check("empty_flush", 32'(mem_write), 0);

    // Randomized stream with random backpressure.
    ready_mode = 2;
    a = INSTRUCTION_OFFSET;
    for (int n = 0; n < 300; n++) begin
      if (($urandom % 10) < 6) a = a + 1;
      else a = INSTRUCTION_OFFSET + 32'($urandom_range(0, 15));
      send_byte(a, 8'($urandom), ($urandom % 8) == 0, r);
      repeat ($urandom_range(0, 2)) tick();
    end
    do_flush();

    // Reset in the middle of a three-byte drain.
    ready_mode = 1;
    send_byte(INSTRUCTION_OFFSET + 32'h60, 8'hA1, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h61, 8'hA2, 0, r);
    send_byte(INSTRUCTION_OFFSET + 32'h62, 8'hA3, 1, r);
    hs_seen = 0;
    for (int i = 0; i < 20 && !hs_seen; i++) tick();
    check("rd_first_write", 32'(hs_seen), 1);
    mon_en = 0;
    reset  = 1'b1;
    #1;
    check("rd_write_drop", 32'(mem_write), 0);
    exp_q.delete();
    m_cnt      = 0;
    m_mask     = '0;
    prev_stall = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rd_idle", 32'(idle), 1);
    check("rd_count", 32'(write_count), 0);
    mon_en = 1;
    repeat (10) tick();
    check("rd_no_write", 32'(mem_write), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
